// File: rtl/ddram_pcm_loader_pkg.sv
// Shared widths, the PCM stream index and the writer state type for the
// DDRAM PCM loader.
package ddram_loader_pkg;

    localparam int DDRAM_AW = 29;
    localparam int IOCTL_AW = 25;
    localparam int LANES    = 8;
    localparam int WORD_AW  = IOCTL_AW - 3;

    localparam logic [7:0] PCM_INDEX = 8'd0;

    typedef enum logic {
        WR_IDLE,
        WR_WRITE
    } wr_state_t;

    // One-hot byte-enable for a lane inside a 64-bit word.
    function automatic logic [LANES-1:0] lane_mask(input logic [2:0] lane);
        return LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/ddram_pcm_loader_if.sv
// Bundle of the hps_io download bus and the DDRAM write port used by the
// PCM loader. "master" is the loader side, "slave" is the environment side.
interface ddram_pcm_loader_if;
    import ddram_loader_pkg::*;

    logic                  ioctl_download;
    logic                  ioctl_wr;
    logic [IOCTL_AW-1:0]   ioctl_addr;
    logic [7:0]            ioctl_dout;
    logic [7:0]            ioctl_index;
    logic                  ioctl_wait;

    logic                  DDRAM_BUSY;
    logic [DDRAM_AW-1:0]   DDRAM_ADDR;
    logic [LANES*8-1:0]    DDRAM_DIN;
    logic [LANES-1:0]      DDRAM_BE;
    logic                  DDRAM_WE;
    logic [7:0]            DDRAM_BURSTCNT;

    modport master (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  DDRAM_BUSY,
        output ioctl_wait,
        output DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_BURSTCNT
    );

    modport slave (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output DDRAM_BUSY,
        input  ioctl_wait,
        input  DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_BURSTCNT
    );

endinterface

// File: rtl/ddram_pcm_loader_byte_packer.sv
// Byte packer for the PCM loader: gathers accepted bytes into one 64-bit word
// with byte enables and raises a flush strobe when the word must move to the
// hold register (lane 7 written, word changed, or download ended). A word
// that must leave while the hold register cannot take it is kept as a
// pending full pack and leaves as soon as the hold frees up.
module ddram_byte_packer
    import ddram_loader_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 byte_valid,
    input  logic [WORD_AW-1:0]   byte_word,
    input  logic [2:0]           byte_lane,
    input  logic [7:0]           byte_data,
    input  logic                 dl_rise,
    input  logic                 dl_fall,
    input  logic                 hold_ready,
    output logic                 flush,
    output logic [WORD_AW-1:0]   flush_word,
    output logic [LANES*8-1:0]   flush_data,
    output logic [LANES-1:0]     flush_be,
    output logic                 pack_valid
);

    logic                 pack_full;
    logic [WORD_AW-1:0]   pack_word;
    logic [LANES*8-1:0]   pack_data;
    logic [LANES-1:0]     pack_be;

    logic                 nxt_valid;
    logic                 nxt_full;
    logic [WORD_AW-1:0]   nxt_word;
    logic [LANES*8-1:0]   nxt_data;
    logic [LANES-1:0]     nxt_be;
    logic [LANES*8-1:0]   merged_data;
    logic [LANES-1:0]     merged_be;
    logic                 cur_valid;

    // Decide what leaves the pack this cycle and what the pack holds next.
    always_comb begin
        cur_valid   = pack_valid && !dl_rise;
        flush       = 1'b0;
        flush_word  = pack_word;
        flush_data  = pack_data;
        flush_be    = pack_be;
        nxt_valid   = cur_valid;
        nxt_full    = pack_full && !dl_rise;
        nxt_word    = pack_word;
        nxt_data    = cur_valid ? pack_data : '0;
        nxt_be      = cur_valid ? pack_be : '0;
        merged_data = '0;
        merged_be   = '0;

        if (nxt_full && hold_ready) begin
            flush     = 1'b1;
            nxt_valid = 1'b0;
            nxt_full  = 1'b0;
            nxt_data  = '0;
            nxt_be    = '0;
        end

        if (byte_valid) begin
            if (nxt_valid && (byte_word != pack_word)) begin
                flush     = 1'b1;
                nxt_valid = 1'b0;
                nxt_full  = 1'b0;
                nxt_data  = '0;
                nxt_be    = '0;
            end
            merged_data = nxt_data;
            merged_data[byte_lane*8 +: 8] = byte_data;
            merged_be   = nxt_be | lane_mask(byte_lane);
            if ((byte_lane == 3'd7) && hold_ready && !flush) begin
                flush      = 1'b1;
                flush_word = byte_word;
                flush_data = merged_data;
                flush_be   = merged_be;
                nxt_valid  = 1'b0;
                nxt_full   = 1'b0;
                nxt_data   = '0;
                nxt_be     = '0;
            end else begin
                nxt_valid = 1'b1;
                nxt_full  = (byte_lane == 3'd7);
                nxt_word  = byte_word;
                nxt_data  = merged_data;
                nxt_be    = merged_be;
            end
        end else if (dl_fall && nxt_valid) begin
            if (hold_ready && !flush) begin
                flush     = 1'b1;
                nxt_valid = 1'b0;
                nxt_full  = 1'b0;
                nxt_data  = '0;
                nxt_be    = '0;
            end else begin
                nxt_full  = 1'b1;
            end
        end
    end

    // Pack register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pack_valid <= 1'b0;
            pack_full  <= 1'b0;
            pack_word  <= '0;
            pack_data  <= '0;
            pack_be    <= '0;
        end else begin
            pack_valid <= nxt_valid;
            pack_full  <= nxt_full;
            pack_word  <= nxt_word;
            pack_data  <= nxt_data;
            pack_be    <= nxt_be;
        end
    end

endmodule

// File: rtl/ddram_pcm_loader.sv
// DDRAM PCM loader: captures the PCM region of the index-0 ROM download,
// packs it into 64-bit words and writes them to DDRAM one beat at a time.
// Optional feature macro: LOADER_CHECKSUM_EN (16-bit byte sum on checksum).
module ddram_pcm_loader
    import ddram_loader_pkg::*;
#(
    parameter logic [IOCTL_AW-1:0] REGION_START = 25'hE8000,
    parameter logic [IOCTL_AW-1:0] REGION_SIZE  = 25'h40000,
    parameter logic [DDRAM_AW-1:0] DDRAM_BASE   = 29'h0600000
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    ddram_pcm_loader_if.master  bus,
    output logic                done,
    output logic [15:0]         checksum
);

    logic                 download_q;
    logic                 dl_rise;
    logic                 dl_fall;
    logic [IOCTL_AW:0]    region_end;
    logic                 in_region;
    logic                 accept;
    logic [IOCTL_AW-1:0]  off;

    logic                 flush;
    logic [WORD_AW-1:0]   flush_word;
    logic [LANES*8-1:0]   flush_data;
    logic [LANES-1:0]     flush_be;
    logic                 pack_valid;

    wr_state_t            state_q;
    wr_state_t            state_d;
    logic                 hold_valid;
    logic                 hold_ready;
    logic [DDRAM_AW-1:0]  hold_addr;
    logic [LANES*8-1:0]   hold_data;
    logic [LANES-1:0]     hold_be;
    logic                 ended;

    assign dl_rise    = bus.ioctl_download && !download_q;
    assign dl_fall    = !bus.ioctl_download && download_q;
    assign region_end = {1'b0, REGION_START} + {1'b0, REGION_SIZE};
    assign in_region  = (bus.ioctl_addr >= REGION_START) &&
                        ({1'b0, bus.ioctl_addr} < region_end);
    assign accept     = bus.ioctl_wr && bus.ioctl_download &&
                        (bus.ioctl_index == PCM_INDEX) && in_region;
    assign off        = bus.ioctl_addr - REGION_START;

    assign hold_valid = (state_q == WR_WRITE);
    assign hold_ready = !hold_valid || !bus.DDRAM_BUSY;

    assign bus.ioctl_wait     = pack_valid && hold_valid;
    assign bus.DDRAM_WE       = hold_valid;
    assign bus.DDRAM_ADDR     = hold_addr;
    assign bus.DDRAM_DIN      = hold_data;
    assign bus.DDRAM_BE       = hold_be;
    assign bus.DDRAM_BURSTCNT = 8'd1;

    ddram_byte_packer u_packer (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .byte_valid (accept),
        .byte_word  (off[IOCTL_AW-1:3]),
        .byte_lane  (off[2:0]),
        .byte_data  (bus.ioctl_dout),
        .dl_rise    (dl_rise),
        .dl_fall    (dl_fall),
        .hold_ready (hold_ready),
        .flush      (flush),
        .flush_word (flush_word),
        .flush_data (flush_data),
        .flush_be   (flush_be),
        .pack_valid (pack_valid)
    );

    // Delayed download flag for edge detection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) download_q <= 1'b0;
        else          download_q <= bus.ioctl_download;
    end

    // Writer state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= WR_IDLE;
        else          state_q <= state_d;
    end

    // Writer next state: a flush always lands in hold, otherwise retire when not busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_IDLE:  if (flush) state_d = WR_WRITE;
            WR_WRITE: if (!flush && !bus.DDRAM_BUSY) state_d = WR_IDLE;
            default:  state_d = WR_IDLE;
        endcase
    end

    // Hold register: loaded on flush, kept stable until the next flush.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_addr <= '0;
            hold_data <= '0;
            hold_be   <= '0;
        end else if (flush) begin
            hold_addr <= DDRAM_BASE + DDRAM_AW'(flush_word);
            hold_data <= flush_data;
            hold_be   <= flush_be;
        end
    end

    // Completion: raised once an ended download has fully drained.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ended <= 1'b0;
            done  <= 1'b0;
        end else if (dl_rise) begin
            ended <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (dl_fall) ended <= 1'b1;
            if (ended && !bus.ioctl_download && !pack_valid && !hold_valid) done <= 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum_q;

    // Wrapping byte sum of accepted bytes, restarted by each new download.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)     sum_q <= 16'h0;
        else if (dl_rise) sum_q <= accept ? {8'h00, bus.ioctl_dout} : 16'h0;
        else if (accept)  sum_q <= sum_q + {8'h00, bus.ioctl_dout};
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0;
`endif

endmodule

// File: tb/tb_ddram_pcm_loader.sv
// Self-checking bench for ddram_pcm_loader: directed scenarios plus a
// randomized stream, compared against a word-level model of the loader.
module tb_ddram_pcm_loader;
    import ddram_loader_pkg::*;

    localparam logic [24:0] RS   = 25'hE8000;
    localparam logic [24:0] RSZ  = 25'h40000;
    localparam logic [28:0] BASE = 29'h0600000;

    typedef struct packed {
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
    } wr_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        done;
    logic [15:0] checksum;
    logic        busy_drv = 1'b0;
    logic        busy_force = 1'b0;
    logic        busy_random = 1'b0;

    int checks = 0;
    int failures = 0;
    int wait_cycles = 0;
    int cmp_base = 0;

    wr_t got_q[$];
    wr_t exp_q[$];

    logic        m_valid;
    logic [21:0] m_word;
    logic [63:0] m_data;
    logic [7:0]  m_be;
    logic [15:0] chk_model;

    ddram_pcm_loader_if bus();

    assign bus.DDRAM_BUSY = busy_drv;

    ddram_pcm_loader #(
        .REGION_START (RS),
        .REGION_SIZE  (RSZ),
        .DDRAM_BASE   (BASE)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .bus      (bus),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    // DDRAM back-pressure source: forced level or random.
    always @(posedge clk_sys) begin
        #1;
        busy_drv = busy_random ? ($urandom_range(0, 2) == 0) : busy_force;
    end

    // Retired-write and stall monitor.
    always @(posedge clk_sys) begin
        if (reset_n && bus.DDRAM_WE && !bus.DDRAM_BUSY)
            got_q.push_back('{addr: bus.DDRAM_ADDR, din: bus.DDRAM_DIN, be: bus.DDRAM_BE});
        if (bus.ioctl_wait) wait_cycles = wait_cycles + 1;
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [15:0] exp_checksum();
`ifdef LOADER_CHECKSUM_EN
        return chk_model;
`else
        return 16'h0;
`endif
    endfunction

    function automatic bit accepted(input logic [24:0] addr, input logic [7:0] idx);
        return (idx == 8'd0) && (addr >= RS) && ({1'b0, addr} < ({1'b0, RS} + {1'b0, RSZ}));
    endfunction

    task automatic model_emit();
        exp_q.push_back('{addr: BASE + 29'(m_word), din: m_data, be: m_be});
        m_valid = 1'b0;
    endtask

    task automatic model_byte(input logic [24:0] addr, input logic [7:0] data, input logic [7:0] idx);
        logic [24:0] o;
        logic [2:0]  l;
        if (accepted(addr, idx)) begin
            chk_model = chk_model + 16'(data);
            o = addr - RS;
            l = o[2:0];
            if (m_valid && (o[24:3] != m_word)) model_emit();
            if (!m_valid) begin
                m_valid = 1'b1;
                m_word  = o[24:3];
                m_data  = '0;
                m_be    = '0;
            end
            m_data[l*8 +: 8] = data;
            m_be[l] = 1'b1;
            if (l == 3'd7) model_emit();
        end
    endtask

    task automatic apply_stimulus(input logic [24:0] addr, input logic [7:0] data, input logic [7:0] idx);
        int n = 0;
        while (bus.ioctl_wait && n < 300) begin
            tick();
            n++;
        end
        if (n == 300) check_output("wait_bound", bus.ioctl_wait, 64'h0);
        bus.ioctl_wr    = 1'b1;
        bus.ioctl_addr  = addr;
        bus.ioctl_dout  = data;
        bus.ioctl_index = idx;
        tick();
        bus.ioctl_wr    = 1'b0;
        model_byte(addr, data, idx);
    endtask

    task automatic start_download();
        bus.ioctl_download = 1'b1;
        m_valid   = 1'b0;
        chk_model = 16'h0;
        tick();
    endtask

    task automatic end_download();
        bus.ioctl_download = 1'b0;
        tick();
        if (m_valid) model_emit();
    endtask

    task automatic wait_writes();
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 500) begin
            tick();
            n++;
        end
        repeat (3) tick();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check_output(tag, done, 64'h1);
    endtask

    task automatic compare_writes(input string tag);
        check_output({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = cmp_base; i < exp_q.size() && i < got_q.size(); i++) begin
            check_output({tag, "_addr"}, got_q[i].addr, exp_q[i].addr);
            check_output({tag, "_din"},  got_q[i].din,  exp_q[i].din);
            check_output({tag, "_be"},   got_q[i].be,   exp_q[i].be);
        end
        cmp_base = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_we"},    bus.DDRAM_WE, 64'h0);
        check_output({tag, "_addr"},  bus.DDRAM_ADDR, 64'h0);
        check_output({tag, "_din"},   bus.DDRAM_DIN, 64'h0);
        check_output({tag, "_be"},    bus.DDRAM_BE, 64'h0);
        check_output({tag, "_wait"},  bus.ioctl_wait, 64'h0);
        check_output({tag, "_done"},  done, 64'h0);
        check_output({tag, "_csum"},  checksum, 64'h0);
        check_output({tag, "_burst"}, bus.DDRAM_BURSTCNT, 64'h1);
    endtask

    initial begin
        int wc0;
        int g0;
        int off_r;
        int r;
        logic [24:0] a;
        logic [7:0]  ix;

        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.ioctl_index    = '0;
        m_valid   = 1'b0;
        m_word    = '0;
        m_data    = '0;
        m_be      = '0;
        chk_model = 16'h0;

        repeat (3) @(posedge clk_sys);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        $display("[TB] aligned word and partial tail");
        start_download();
        for (int i = 0; i < 8; i++) apply_stimulus(RS + 25'(i), 8'h11 + 8'(i), 8'd0);
        check_output("aligned_we",   bus.DDRAM_WE, 64'h1);
        check_output("aligned_addr", bus.DDRAM_ADDR, 64'h0600000);
        check_output("aligned_din",  bus.DDRAM_DIN, 64'h1817161514131211);
        check_output("aligned_be",   bus.DDRAM_BE, 64'hFF);
        for (int i = 0; i < 3; i++) apply_stimulus(RS + 25'(8 + i), 8'h21 + 8'(i), 8'd0);
        end_download();
        check_output("tail_we",   bus.DDRAM_WE, 64'h1);
        check_output("tail_addr", bus.DDRAM_ADDR, 64'h0600001);
        check_output("tail_din",  bus.DDRAM_DIN, 64'h0000000000232221);
        check_output("tail_be",   bus.DDRAM_BE, 64'h07);
        wait_done("tail_done");
        wait_writes();
        compare_writes("aligned");
        check_output("tail_csum", checksum, exp_checksum());

        $display("[TB] back-pressure");
        start_download();
        check_output("done_clear", done, 64'h0);
        wc0 = wait_cycles;
        busy_force = 1'b1;
        fork
            begin
                repeat (20) tick();
                busy_force = 1'b0;
            end
            begin
                for (int i = 0; i < 16; i++) apply_stimulus(RS + 25'h100 + 25'(i), 8'h40 + 8'(i), 8'd0);
            end
        join
        end_download();
        wait_writes();
        check_output("bp_wait_seen", (wait_cycles > wc0), 64'h1);
        compare_writes("bp");
        wait_done("bp_done");

        $display("[TB] filtering");
        start_download();
        wc0 = wait_cycles;
        g0  = got_q.size();
        apply_stimulus(RS - 25'd1, 8'h55, 8'd0);
        apply_stimulus(RS, 8'h66, 8'd1);
        apply_stimulus(RS + RSZ, 8'h77, 8'd0);
        repeat (4) tick();
        check_output("filter_writes", got_q.size(), g0);
        check_output("filter_wait",   wait_cycles, wc0);
        check_output("filter_csum",   checksum, exp_checksum());
        end_download();
        wait_done("filter_done");

        $display("[TB] non-contiguous and region end");
        start_download();
        apply_stimulus(RS + 25'h3, 8'hA3, 8'd0);
        apply_stimulus(RS + 25'h10, 8'hB0, 8'd0);
        check_output("nc_we0",   bus.DDRAM_WE, 64'h1);
        check_output("nc_addr0", bus.DDRAM_ADDR, 64'h0600000);
        check_output("nc_be0",   bus.DDRAM_BE, 64'h08);
        end_download();
        check_output("nc_addr1", bus.DDRAM_ADDR, 64'h0600002);
        check_output("nc_be1",   bus.DDRAM_BE, 64'h01);
        start_download();
        apply_stimulus(RS + RSZ - 25'd1, 8'hEE, 8'd0);
        check_output("last_addr", bus.DDRAM_ADDR, 64'h0607FFF);
        check_output("last_din",  bus.DDRAM_DIN, 64'hEE00000000000000);
        check_output("last_be",   bus.DDRAM_BE, 64'h80);
        end_download();
        wait_writes();
        compare_writes("nc");

        $display("[TB] randomized stream");
        start_download();
        busy_random = 1'b1;
        off_r = 0;
        for (int k = 0; k < 120; k++) begin
            r  = $urandom_range(0, 19);
            ix = 8'd0;
            if (r == 0)      a = RS - 25'd1 - 25'($urandom_range(0, 7));
            else if (r == 1) a = RS + RSZ + 25'($urandom_range(0, 7));
            else if (r == 2) begin
                a  = RS + 25'(off_r);
                ix = 8'd1;
            end else begin
                if (r == 3) off_r = $urandom_range(0, 511);
                a = RS + 25'(off_r);
                off_r++;
            end
            apply_stimulus(a, 8'($urandom), ix);
            if (r == 4) tick();
        end
        end_download();
        busy_random = 1'b0;
        wait_writes();
        compare_writes("rand");
        wait_done("rand_done");
        check_output("rand_csum", checksum, exp_checksum());

        $display("[TB] checksum and reset mid-write");
        start_download();
        apply_stimulus(RS + 25'h20, 8'h80, 8'd0);
        apply_stimulus(RS + 25'h21, 8'h90, 8'd0);
        end_download();
        wait_writes();
        compare_writes("csum");
        check_output("csum_value", checksum, exp_checksum());
        start_download();
        busy_force = 1'b1;
        tick();
        apply_stimulus(RS + 25'h2F, 8'h5A, 8'd0);
        check_output("rst_pre_we", bus.DDRAM_WE, 64'h1);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_reset_values("rst_mid");
        busy_force = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
